// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage of the BWT inexact-match
// search engine.
//   - Position code constants and helpers:
//       NONE=0, STOP_1=1, STOP_2=2, INS(s)=3+2s, DEL(s)=4+2s
//   - Default frame layout used by neighbouring stages (fetch / call stack)
//     when they run with the default widths.
package ex_pkg;

    localparam int POS_NONE   = 0;
    localparam int POS_STOP_1 = 1;
    localparam int POS_STOP_2 = 2;

    // Insertion position for symbol s.
    function automatic int pos_ins(input int s);
        return 3 + 2 * s;
    endfunction

    // Deletion position for symbol s.
    function automatic int pos_del(input int s);
        return 4 + 2 * s;
    endfunction

    localparam int DEF_IW = 8;
    localparam int DEF_KW = 8;
    localparam int DEF_AW = 12;

    // Backtracking frame as stored by the call-stack manager.
    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_IW-1:0] i;
        logic [DEF_IW-1:0] z;
        logic [DEF_IW-1:0] d_i;
        logic [DEF_KW-1:0] k;
        logic [DEF_KW-1:0] l;
    } frame_t;

endpackage

// File: rtl/ex_decide.sv
// ex_decide: purely combinational single-step decision of the backtracking
// recursion.
// Inputs : position_in (PW), i_in/z_in/d_i_in (IW, signed), k_in/l_in,
//          c_in, occ_k_in, occ_l_in (KW, unsigned)
// Outputs: over_1, over_2, finish, err, en_new_position, new_position (PW),
//          new_call, i_new/z_new (IW), k_new/l_new (KW)
module ex_decide
    import ex_pkg::*;
#(
    parameter int IW   = 8,
    parameter int KW   = 8,
    parameter int NSYM = 4,
    parameter int PW   = 5
) (
    input  logic [PW-1:0] position_in,
    input  logic [IW-1:0] i_in,
    input  logic [IW-1:0] z_in,
    input  logic [IW-1:0] d_i_in,
    input  logic [KW-1:0] k_in,
    input  logic [KW-1:0] l_in,
    input  logic [KW-1:0] c_in,
    input  logic [KW-1:0] occ_k_in,
    input  logic [KW-1:0] occ_l_in,
    output logic          over_1,
    output logic          over_2,
    output logic          finish,
    output logic          err,
    output logic          en_new_position,
    output logic [PW-1:0] new_position,
    output logic          new_call,
    output logic [IW-1:0] i_new,
    output logic [IW-1:0] z_new,
    output logic [KW-1:0] k_new,
    output logic [KW-1:0] l_new
);

    // Child interval computed one bit wider so a carry out of KW bits can be
    // detected and treated as an empty interval.
    logic [KW:0] kp;
    logic [KW:0] lp;

    assign kp = {1'b0, c_in} + {1'b0, occ_k_in} + (KW+1)'(1);
    assign lp = {1'b0, c_in} + {1'b0, occ_l_in};

    always_comb begin
        int pos;
        pos             = int'(position_in);
        over_1          = 1'b0;
        over_2          = 1'b0;
        finish          = 1'b0;
        err             = 1'b0;
        en_new_position = 1'b0;
        new_position    = '0;
        new_call        = 1'b0;
        i_new           = '0;
        z_new           = '0;
        k_new           = '0;
        l_new           = '0;

        if (pos == POS_NONE) begin
            if ($signed(z_in) < $signed(d_i_in)) begin
                over_1 = 1'b1;
            end else begin
                en_new_position = 1'b1;
                new_position    = PW'(POS_STOP_1);
            end
        end else if (pos == POS_STOP_1) begin
            if (i_in[IW-1]) begin
                over_2 = 1'b1;
            end else begin
                en_new_position = 1'b1;
                new_position    = PW'(POS_STOP_2);
            end
        end else if (pos == POS_STOP_2) begin
            en_new_position = 1'b1;
            new_position    = PW'(pos_ins(0));
            new_call        = 1'b1;
            i_new           = i_in - IW'(1);
            z_new           = z_in - IW'(1);
            k_new           = k_in;
            l_new           = l_in;
        end else if (pos >= pos_ins(0) && pos < pos_ins(NSYM) &&
                     ((pos - pos_ins(0)) % 2) == 0) begin
            // INS(s): DEL(s) is the next code, INS(s+1) is two codes on.
            if (kp <= lp && !kp[KW] && !lp[KW]) begin
                new_call        = 1'b1;
                en_new_position = 1'b1;
                new_position    = position_in + PW'(1);
                i_new           = i_in;
                z_new           = z_in - IW'(1);
                k_new           = kp[KW-1:0];
                l_new           = lp[KW-1:0];
            end else if (pos < pos_ins(NSYM - 1)) begin
                en_new_position = 1'b1;
                new_position    = position_in + PW'(2);
            end else begin
                finish = 1'b1;
            end
        end else begin
            // DEL(s) is not handled by this stage; everything else is illegal.
            err = 1'b1;
        end
    end

endmodule

// File: rtl/ex_pipe.sv
// ex_pipe: registered execute stage. Accepts one backtracking frame per
// valid/ready handshake, decides one recursion step and presents the result
// from a one-entry output register. Counts accepted child calls.
// Ports:
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready, position_in, addr_in, i_in, z_in, d_i_in, k_in, l_in,
//   c_in, occ_k_in, occ_l_in          : input frame
//   clr_cnt                           : clears call_count
//   out_valid/out_ready, out_addr, out_k, out_l, over_1, over_2, finish,
//   err, en_new_position, new_position, new_call, i_new, z_new, k_new, l_new
//                                     : registered result
//   call_count                        : saturating count of drained child calls
module ex_pipe
    import ex_pkg::*;
#(
    parameter int IW   = 8,
    parameter int KW   = 8,
    parameter int AW   = 12,
    parameter int NSYM = 4,
    parameter int PW   = 5,
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] position_in,
    input  logic [AW-1:0] addr_in,
    input  logic [IW-1:0] i_in,
    input  logic [IW-1:0] z_in,
    input  logic [IW-1:0] d_i_in,
    input  logic [KW-1:0] k_in,
    input  logic [KW-1:0] l_in,
    input  logic [KW-1:0] c_in,
    input  logic [KW-1:0] occ_k_in,
    input  logic [KW-1:0] occ_l_in,
    input  logic          clr_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [KW-1:0] out_k,
    output logic [KW-1:0] out_l,
    output logic          over_1,
    output logic          over_2,
    output logic          finish,
    output logic          err,
    output logic          en_new_position,
    output logic [PW-1:0] new_position,
    output logic          new_call,
    output logic [IW-1:0] i_new,
    output logic [IW-1:0] z_new,
    output logic [KW-1:0] k_new,
    output logic [KW-1:0] l_new,
    output logic [CW-1:0] call_count
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [KW-1:0] k;
        logic [KW-1:0] l;
        logic          over_1;
        logic          over_2;
        logic          finish;
        logic          err;
        logic          en_new_position;
        logic [PW-1:0] new_position;
        logic          new_call;
        logic [IW-1:0] i_new;
        logic [IW-1:0] z_new;
        logic [KW-1:0] k_new;
        logic [KW-1:0] l_new;
    } result_t;

    result_t       result_next;
    result_t       result_reg;
    logic          out_valid_reg;
    logic [CW-1:0] call_count_reg;
    logic          accept;
    logic          drain;

    assign result_next.addr = addr_in;
    assign result_next.k    = k_in;
    assign result_next.l    = l_in;

    ex_decide #(
        .IW   (IW),
        .KW   (KW),
        .NSYM (NSYM),
        .PW   (PW)
    ) u_decide (
        .position_in     (position_in),
        .i_in            (i_in),
        .z_in            (z_in),
        .d_i_in          (d_i_in),
        .k_in            (k_in),
        .l_in            (l_in),
        .c_in            (c_in),
        .occ_k_in        (occ_k_in),
        .occ_l_in        (occ_l_in),
        .over_1          (result_next.over_1),
        .over_2          (result_next.over_2),
        .finish          (result_next.finish),
        .err             (result_next.err),
        .en_new_position (result_next.en_new_position),
        .new_position    (result_next.new_position),
        .new_call        (result_next.new_call),
        .i_new           (result_next.i_new),
        .z_new           (result_next.z_new),
        .k_new           (result_next.k_new),
        .l_new           (result_next.l_new)
    );

    // The output slot frees up in the same cycle it is drained, so a new
    // frame can replace the old result on the same edge without a bubble.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready && rst_n;
    assign drain    = out_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            result_reg    <= result_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Calls are counted when the downstream stack manager takes them, not
    // when they are decided; a result discarded by reset is never counted.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            call_count_reg <= '0;
        end else if (drain && result_reg.new_call && call_count_reg != '1) begin
            call_count_reg <= call_count_reg + CW'(1);
        end
    end

    assign out_valid       = out_valid_reg;
    assign out_addr        = result_reg.addr;
    assign out_k           = result_reg.k;
    assign out_l           = result_reg.l;
    assign over_1          = result_reg.over_1;
    assign over_2          = result_reg.over_2;
    assign finish          = result_reg.finish;
    assign err             = result_reg.err;
    assign en_new_position = result_reg.en_new_position;
    assign new_position    = result_reg.new_position;
    assign new_call        = result_reg.new_call;
    assign i_new           = result_reg.i_new;
    assign z_new           = result_reg.z_new;
    assign k_new           = result_reg.k_new;
    assign l_new           = result_reg.l_new;
    assign call_count      = call_count_reg;

endmodule

// File: tb/tb_ex_pipe.sv
// tb_ex_pipe: table-driven directed test of ex_pipe with default parameters,
// plus hand-written backpressure, counter-clear and reset sequences.
module tb_ex_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  position_in;
    logic [11:0] addr_in;
    logic [7:0]  i_in, z_in, d_i_in, k_in, l_in, c_in, occ_k_in, occ_l_in;
    logic        clr_cnt;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_addr;
    logic [7:0]  out_k, out_l;
    logic        over_1, over_2, finish, err, en_new_position, new_call;
    logic [4:0]  new_position;
    logic [7:0]  i_new, z_new, k_new, l_new;
    logic [15:0] call_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_pipe dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .position_in     (position_in),
        .addr_in         (addr_in),
        .i_in            (i_in),
        .z_in            (z_in),
        .d_i_in          (d_i_in),
        .k_in            (k_in),
        .l_in            (l_in),
        .c_in            (c_in),
        .occ_k_in        (occ_k_in),
        .occ_l_in        (occ_l_in),
        .clr_cnt         (clr_cnt),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_addr        (out_addr),
        .out_k           (out_k),
        .out_l           (out_l),
        .over_1          (over_1),
        .over_2          (over_2),
        .finish          (finish),
        .err             (err),
        .en_new_position (en_new_position),
        .new_position    (new_position),
        .new_call        (new_call),
        .i_new           (i_new),
        .z_new           (z_new),
        .k_new           (k_new),
        .l_new           (l_new),
        .call_count      (call_count)
    );

    typedef struct {
        logic [4:0]  pos;
        logic [11:0] addr;
        logic [7:0]  i, z, d, k, l, c, ok, ol;
        logic [3:0]  flags;   // {over_1, over_2, finish, err}
        logic        en;
        logic [4:0]  np;
        logic        nc;
        logic [7:0]  in_, zn, kn, ln;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [4:0] pos, input logic [7:0] i, z, d, k, l, c, ok, ol,
                                input logic [3:0] flags, input logic en, input logic [4:0] np,
                                input logic nc, input logic [7:0] in_, zn, kn, ln);
        vec_t v;
        v.pos = pos; v.addr = 12'h000; v.i = i; v.z = z; v.d = d; v.k = k; v.l = l;
        v.c = c; v.ok = ok; v.ol = ol; v.flags = flags; v.en = en; v.np = np;
        v.nc = nc; v.in_ = in_; v.zn = zn; v.kn = kn; v.ln = ln;
        return v;
    endfunction

    function automatic logic [127:0] exp_pack(input vec_t v);
        return {57'b0, v.addr, v.k, v.l, v.flags, v.en, v.np, v.nc, v.in_, v.zn, v.kn, v.ln};
    endfunction

    function automatic logic [127:0] dut_pack();
        return {57'b0, out_addr, out_k, out_l, over_1, over_2, finish, err,
                en_new_position, new_position, new_call, i_new, z_new, k_new, l_new};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic drive(input vec_t v);
        position_in = v.pos; addr_in = v.addr; i_in = v.i; z_in = v.z; d_i_in = v.d;
        k_in = v.k; l_in = v.l; c_in = v.c; occ_k_in = v.ok; occ_l_in = v.ol;
    endtask

    initial begin
        int exp_cnt;
        // pos  i     z     d     k   l   c    ok  ol  flags    en np  nc in_   zn    kn   ln
        vecs[0]  = mk(0,  0,    8'hFF,0,    3,  9,  0,   0,  0,  4'b1000, 0, 0,  0, 0,    0,    0,   0);
        vecs[1]  = mk(0,  0,    2,    1,    3,  9,  0,   0,  0,  4'b0000, 1, 1,  0, 0,    0,    0,   0);
        vecs[2]  = mk(0,  0,    8'h80,8'h7F,3,  9,  0,   0,  0,  4'b1000, 0, 0,  0, 0,    0,    0,   0);
        vecs[3]  = mk(0,  0,    8'h7F,8'h80,3,  9,  0,   0,  0,  4'b0000, 1, 1,  0, 0,    0,    0,   0);
        vecs[4]  = mk(1,  8'hFF,0,    0,    1,  2,  0,   0,  0,  4'b0100, 0, 0,  0, 0,    0,    0,   0);
        vecs[5]  = mk(1,  0,    0,    0,    1,  2,  0,   0,  0,  4'b0000, 1, 2,  0, 0,    0,    0,   0);
        vecs[6]  = mk(2,  5,    2,    0,    3,  9,  0,   0,  0,  4'b0000, 1, 3,  1, 4,    1,    3,   9);
        vecs[7]  = mk(2,  0,    8'h80,0,    7,  20, 0,   0,  0,  4'b0000, 1, 3,  1, 8'hFF,8'h7F,7,   20);
        vecs[8]  = mk(5,  7,    3,    0,    0,  0,  10,  2,  4,  4'b0000, 1, 6,  1, 7,    2,    13,  14);
        vecs[9]  = mk(5,  7,    3,    0,    0,  0,  10,  2,  1,  4'b0000, 1, 7,  0, 0,    0,    0,   0);
        vecs[10] = mk(9,  7,    3,    0,    0,  0,  10,  2,  1,  4'b0010, 0, 0,  0, 0,    0,    0,   0);
        vecs[11] = mk(9,  7,    3,    0,    0,  0,  0,   0,  5,  4'b0000, 1, 10, 1, 7,    2,    1,   5);
        vecs[12] = mk(3,  7,    3,    0,    0,  0,  250, 10, 20, 4'b0000, 1, 5,  0, 0,    0,    0,   0);
        vecs[13] = mk(3,  7,    3,    0,    0,  0,  5,   2,  3,  4'b0000, 1, 4,  1, 7,    2,    8,   8);
        vecs[14] = mk(7,  7,    3,    0,    0,  0,  200, 0,  60, 4'b0000, 1, 9,  0, 0,    0,    0,   0);
        vecs[15] = mk(7,  1,    1,    0,    0,  0,  200, 0,  55, 4'b0000, 1, 8,  1, 1,    0,    201, 255);
        vecs[16] = mk(4,  1,    1,    0,    5,  6,  0,   0,  0,  4'b0001, 0, 0,  0, 0,    0,    0,   0);
        vecs[17] = mk(31, 1,    1,    0,    5,  6,  0,   0,  0,  4'b0001, 0, 0,  0, 0,    0,    0,   0);
        vecs[18] = mk(11, 1,    1,    0,    5,  6,  0,   0,  0,  4'b0001, 0, 0,  0, 0,    0,    0,   0);
        vecs[19] = mk(10, 1,    1,    0,    5,  6,  0,   0,  0,  4'b0001, 0, 0,  0, 0,    0,    0,   0);
        vecs[20] = mk(7,  1,    1,    0,    0,  0,  0,   0,  0,  4'b0000, 1, 9,  0, 0,    0,    0,   0);
        for (int n = 0; n < NV; n++) vecs[n].addr = 12'h100 + 12'(n);

        // Reset with a frame presented: it must be dropped.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; clr_cnt = 1'b0;
        drive(vecs[6]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_fields", dut_pack(), 128'(0));
        check("reset_call_count", 128'(call_count), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;

        // Table: streamed back-to-back with out_ready held high.
        exp_cnt = 0;
        for (int n = 0; n < NV; n++) begin
            drive(vecs[n]);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            $display("vec %0d pos=%0d out=%h", n, vecs[n].pos, dut_pack());
            check($sformatf("vec%0d_valid", n), 128'(out_valid), 128'(1));
            check($sformatf("vec%0d_result", n), dut_pack(), exp_pack(vecs[n]));
            // Each call in the table is drained on the edge after it appears.
            check($sformatf("vec%0d_count", n), 128'(call_count), 128'(exp_cnt));
            if (vecs[n].nc) exp_cnt++;
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("table_drain_valid", 128'(out_valid), 128'(0));
        check("table_call_count", 128'(call_count), 128'(exp_cnt));

        clr_cnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_cnt = 1'b0;
        check("clr_idle", 128'(call_count), 128'(0));

        // Backpressure: A held for 3 cycles while B waits, then A,B,C stream.
        out_ready = 1'b0;
        drive(vecs[6]); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        $display("bp hold A out=%h", dut_pack());
        check("bp_A_valid", 128'(out_valid), 128'(1));
        check("bp_A_result", dut_pack(), exp_pack(vecs[6]));
        drive(vecs[7]);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_hold%0d_in_ready", n), 128'(in_ready), 128'(0));
            check($sformatf("bp_hold%0d_result", n), dut_pack(), exp_pack(vecs[6]));
            check($sformatf("bp_hold%0d_count", n), 128'(call_count), 128'(0));
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        $display("bp stream B out=%h", dut_pack());
        check("bp_B_result", dut_pack(), exp_pack(vecs[7]));
        check("bp_B_count", 128'(call_count), 128'(1));
        drive(vecs[1]);
        @(posedge clk);
        @(negedge clk);
        $display("bp stream C out=%h", dut_pack());
        check("bp_C_result", dut_pack(), exp_pack(vecs[1]));
        check("bp_C_count", 128'(call_count), 128'(2));
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("bp_end_valid", 128'(out_valid), 128'(0));
        check("bp_end_count", 128'(call_count), 128'(2));

        // clr_cnt on the same edge a call is drained: clear wins.
        drive(vecs[6]); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; clr_cnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_cnt = 1'b0;
        $display("clr coincide count=%0d", call_count);
        check("clr_priority", 128'(call_count), 128'(0));

        // One counted call, then reset during a held result.
        drive(vecs[6]); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_count", 128'(call_count), 128'(1));
        out_ready = 1'b0;
        drive(vecs[7]); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_before_reset", 128'(out_valid), 128'(1));
        rst_n = 1'b0;
        drive(vecs[8]);
        @(posedge clk);
        @(negedge clk);
        $display("reset mid-hold valid=%0d count=%0d", out_valid, call_count);
        check("midreset_valid", 128'(out_valid), 128'(0));
        check("midreset_count", 128'(call_count), 128'(0));
        check("midreset_fields", dut_pack(), 128'(0));
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_valid", 128'(out_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_pipe.md
# ex_pipe

Registered, parametrised successor to the inexact-match execute stage of the BWT search engine. It accepts one backtracking frame per handshake: position code, suffix-array interval, residual read index and difference budget. It decides one step of the recursion and emits a registered result with valid/ready flow control:

- terminate with over_1, over_2 or finish, or
- advance the position code, optionally spawning a child call.

Compared with the previous generation, it adds a generalised alphabet, child-interval computation, an error flag for illegal positions and a call counter. It sits between the frame/occurrence fetch stage and the call-stack manager.

## Interface
Parameters:
- IW, 8, width of i/z/D(i); two's complement signed
- KW, 8, width of k, l, C, occ values; unsigned
- AW, 12, frame address width
- NSYM, 4, alphabet size (≥1)
- PW, 5, position code width; must satisfy 2·NSYM+3 ≤ 2^PW
- CW, 16, call counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input frame valid
- in_ready  out  1  stage can accept
- position_in  in  PW  current position code
- addr_in  in  AW  frame address
- i_in, z_in, d_i_in  in  IW  read index, difference budget, D(i) bound
- k_in, l_in  in  KW  current interval
- c_in  in  KW  C(s) for symbol of position_in
- occ_k_in, occ_l_in  in  KW  Occ(s,k−1), Occ(s,l)
- clr_cnt  in  1  synchronous clear of call_count
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_addr  out  AW; out_k, out_l  out  KW  echoed frame fields
- over_1, over_2, finish, err  out  1  termination/error flags
- en_new_position  out  1; new_position  out  PW
- new_call  out  1; i_new, z_new  out  IW; k_new, l_new  out  KW
- call_count  out  CW  accepted child calls, saturating

## Operation
Position codes:
- NONE=0, STOP_1=1, STOP_2=2
- INS(s)=3+2s, DEL(s)=4+2s, for s in 0..NSYM−1
- all other codes are illegal

Decision on the captured frame (fields not listed are 0; out_addr/k/l always echo input):
- NONE: if signed z < signed d_i → over_1=1. Else en_new_position=1, new_position=STOP_1.
- STOP_1: if signed i < 0 → over_2=1. Else en_new_position=1, new_position=STOP_2.
- STOP_2: en_new_position=1, new_position=INS(0), new_call=1, i_new=i−1, z_new=z−1, k_new=k, l_new=l.
- INS(s): compute kp=c+occ_k+1 and lp=c+occ_l at KW+1 bits.
  - If kp ≤ lp and kp[KW]=0 and lp[KW]=0 → new_call=1, en_new_position=1, new_position=DEL(s), i_new=i, z_new=z−1, k_new=kp, l_new=lp.
  - Else if s<NSYM−1 → en_new_position=1, new_position=INS(s+1).
  - Else → finish=1.
- DEL(s) or illegal code: err=1, all other flags 0.
- IW arithmetic wraps modulo 2^IW. z=−(2^(IW−1)) minus 1 is not flagged.

call_count:
- Increments on out_valid & out_ready & new_call; saturates at 2^CW−1.
- clr_cnt zeroes it and has priority over an increment in the same cycle.

## Timing
- One-entry output register. in_ready = !out_valid | out_ready (combinational; frames may stream back-to-back).
- Accept = in_valid & in_ready & rst_n. Result appears on outputs the next cycle with out_valid=1, and all outputs are held stable until out_ready.
- Simultaneous accept and drain: the new result replaces the old one in the same edge, with no bubble.
- out_valid falls after drain with no new accept. Output fields keep their last values but are don't-care.
- Reset (rst_n=0 at clk edge): out_valid=0, all flags/fields/new_position=0, call_count=0. A frame presented during reset is dropped. Reset mid-hold discards the pending result.
- Latency 1 cycle; throughput 1 frame/cycle.

## Structure
- Shared package ex_pkg: position code constants/functions pos_ins(s), pos_del(s), POS_NONE/STOP_1/STOP_2, and a frame struct type parametrised by IW/KW/AW.
- One natural sub-module: ex_decide, a purely combinational decision function. ex_pipe holds the valid register, output register and counter.

## Test plan
- NONE, z=−1, d_i=0 → next cycle out_valid=1, over_1=1, new_position=0; z=2, d_i=1 → new_position=1.
- STOP_1 i=0xFF (−1) → over_2=1; STOP_2 i=5, z=2, k=3, l=9 → new_call=1, new_position=3, i_new=4, z_new=1, k_new=3, l_new=9, call_count=1 after drain.
- INS(1)=5, c=10, occ_k=2, occ_l=4 → kp=13, lp=14, new_call=1, new_position=6, k_new=13, l_new=14; occ_l=1 → new_position=7, no call; INS(3)=9 failing → finish=1.
- INS with c=250, occ_k=10, occ_l=20 (KW=8) → overflow, no call, new_position=INS(s+1); position 4 or 31 → err=1.
- out_ready low 3 cycles with in_valid high → in_ready=0 and outputs stable; then out_ready high → back-to-back results at 1/cycle, none lost or duplicated.
- rst_n low while out_valid=1 → next cycle out_valid=0, call_count=0; clr_cnt coinciding with a counted call → call_count=0.
